// File: rtl/econet_tx_arbiter.sv
`default_nettype none
// ============================================================================
// econet_tx_arbiter: round-robin owner of the shared HDLC transmitter with line
// qualification, collision backoff and done/fail reporting.     Revision 1.0
// ============================================================================
module econet_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int IDLE_CYCLES  = 32,
  parameter int BACKOFF_BITS = 4,
  parameter int SLOT_CYCLES  = 16,
  parameter int MAX_RETRY    = 7
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            rx_idle_i,
  input  logic            no_clock_i,
  input  logic            tx_done_i,
  input  logic            tx_collide_i,
  output logic [NREQ-1:0] grant_o,
  output logic            tx_start_o,
  output logic            tx_abort_o,
  output logic            done_o,
  output logic            fail_o,
  output logic            busy_o
);

  localparam int c_PTR_W   = $clog2(NREQ);
  localparam int c_IC_W    = $clog2(IDLE_CYCLES + 1);
  localparam int c_NC_MAX  = 4 * IDLE_CYCLES;
  localparam int c_NC_W    = $clog2(c_NC_MAX + 1);
  localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int c_SLOT_W  = BACKOFF_BITS + 1;
  localparam int c_CYC_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LINE = 2'd1,
    S_ACTIVE    = 2'd2,
    S_BACKOFF   = 2'd3
  } state_t;

  state_t                state_q,    state_d;
  logic [NREQ-1:0]       grant_q,    grant_d;
  logic [c_PTR_W-1:0]    win_q,      win_d;
  logic [c_PTR_W-1:0]    rr_q,       rr_d;
  logic [c_RETRY_W-1:0]  retry_q,    retry_d;
  logic [c_IC_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [c_NC_W-1:0]     nc_cnt_q,   nc_cnt_d;
  logic [c_SLOT_W-1:0]   slot_q,     slot_d;
  logic [c_CYC_W-1:0]    cyc_q,      cyc_d;
  logic [15:0]           lfsr_q,     lfsr_d;
  logic                  start_q,    start_d;
  logic                  abort_q,    abort_d;
  logic                  done_q,     done_d;
  logic                  fail_q,     fail_d;
  logic                  busy_q,     busy_d;

  logic                  w_line_ok;
  logic                  w_found;
  logic [c_PTR_W-1:0]    w_win;
  logic [c_PTR_W-1:0]    w_scan;
  logic                  w_enter_wait;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    if (p == c_PTR_W'(NREQ - 1)) return '0;
    return p + c_PTR_W'(1);
  endfunction

  assign w_line_ok = rx_idle_i & ~no_clock_i;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_i[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
      w_scan = ptr_inc(w_scan);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    win_d        = win_q;
    rr_d         = rr_q;
    retry_d      = retry_q;
    slot_d       = slot_q;
    cyc_d        = cyc_q;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    w_enter_wait = 1'b0;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    if (!w_line_ok)                                   idle_cnt_d = '0;
    else if (idle_cnt_q == c_IC_W'(IDLE_CYCLES))      idle_cnt_d = idle_cnt_q;
    else                                              idle_cnt_d = idle_cnt_q + c_IC_W'(1);

    if (!no_clock_i)                                  nc_cnt_d = '0;
    else if (nc_cnt_q == c_NC_W'(c_NC_MAX))           nc_cnt_d = nc_cnt_q;
    else                                              nc_cnt_d = nc_cnt_q + c_NC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          grant_d      = NREQ'(1) << w_win;
          win_d        = w_win;
          rr_d         = ptr_inc(w_win);
          retry_d      = '0;
          state_d      = S_WAIT_LINE;
          w_enter_wait = 1'b1;
        end
      end
      S_WAIT_LINE: begin
        if (!req_i[win_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (no_clock_i && nc_cnt_q == c_NC_W'(c_NC_MAX - 1)) begin
          fail_d  = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end else if (idle_cnt_q == c_IC_W'(IDLE_CYCLES)) begin
          start_d = 1'b1;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A lost line clock overrides any completion reported in the same cycle.
        if (no_clock_i) begin
          abort_d = 1'b1;
          fail_d  = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end else if (tx_done_i) begin
          if (!tx_collide_i) begin
            done_d  = 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
          end else if (retry_q < c_RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + c_RETRY_W'(1);
            slot_d  = c_SLOT_W'(lfsr_q[BACKOFF_BITS-1:0]) + c_SLOT_W'(1);
            cyc_d   = c_CYC_W'(SLOT_CYCLES - 1);
            state_d = S_BACKOFF;
          end else begin
            fail_d  = 1'b1;
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_BACKOFF: begin
        if (cyc_q == '0) begin
          if (slot_q == c_SLOT_W'(1)) begin
            state_d      = S_WAIT_LINE;
            w_enter_wait = 1'b1;
          end else begin
            slot_d = slot_q - c_SLOT_W'(1);
            cyc_d  = c_CYC_W'(SLOT_CYCLES - 1);
          end
        end else begin
          cyc_d = cyc_q - c_CYC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line must re-qualify from scratch every time we start waiting on it.
    if (w_enter_wait) begin
      idle_cnt_d = '0;
      nc_cnt_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      win_q      <= '0;
      rr_q       <= '0;
      retry_q    <= '0;
      idle_cnt_q <= '0;
      nc_cnt_q   <= '0;
      slot_q     <= '0;
      cyc_q      <= '0;
      lfsr_q     <= 16'hACE1;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      win_q      <= win_d;
      rr_q       <= rr_d;
      retry_q    <= retry_d;
      idle_cnt_q <= idle_cnt_d;
      nc_cnt_q   <= nc_cnt_d;
      slot_q     <= slot_d;
      cyc_q      <= cyc_d;
      lfsr_q     <= lfsr_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign tx_start_o = start_q;
  assign tx_abort_o = abort_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign busy_o     = busy_q;

endmodule
`default_nettype wire
